// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Owns the PC, drives the
// instruction-cache request and absorbs stalls/redirects around a non-abortable read.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000060,
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ir_out,
    output logic [31:0] pc_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {StFetch, StHold, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] buf_ir_q, buf_ir_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic [31:0] target;
    logic [31:0] fetch_pc_inc;

    assign target       = {redirect_pc[31:2], 2'b00};
    assign fetch_pc_inc = fetch_pc_q + 32'd4;

    assign imem_address = {fetch_pc_q[31:2], 2'b00};
    assign imem_read    = (state_q != StHold);

    assign ir_out    = ir_q;
    assign pc_out    = pc_q;
    assign valid_out = valid_q;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        redir_pc_d = redir_pc_q;
        buf_ir_d   = buf_ir_q;
        buf_pc_d   = buf_pc_q;
        ir_d       = ir_q;
        pc_d       = pc_q;
        valid_d    = valid_q;

        unique case (state_q)
            StFetch: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    ir_d    = NOP_INSN;
                    if (imem_resp) begin
                        fetch_pc_d = target;
                    end else begin
                        // Cache cannot abort: park the target until the old read returns.
                        redir_pc_d = target;
                        state_d    = StDrop;
                    end
                end else if (imem_resp) begin
                    fetch_pc_d = fetch_pc_inc;
                    if (!stall) begin
                        ir_d    = imem_rdata;
                        pc_d    = fetch_pc_q;
                        valid_d = 1'b1;
                    end else begin
                        buf_ir_d = imem_rdata;
                        buf_pc_d = fetch_pc_q;
                        state_d  = StHold;
                    end
                end else if (!stall) begin
                    valid_d = 1'b0;
                    ir_d    = NOP_INSN;
                end
            end
            StHold: begin
                if (redirect_valid) begin
                    valid_d    = 1'b0;
                    ir_d       = NOP_INSN;
                    fetch_pc_d = target;
                    state_d    = StFetch;
                end else if (!stall) begin
                    ir_d    = buf_ir_q;
                    pc_d    = buf_pc_q;
                    valid_d = 1'b1;
                    state_d = StFetch;
                end
            end
            StDrop: begin
                valid_d = 1'b0;
                ir_d    = NOP_INSN;
                if (redirect_valid) begin
                    redir_pc_d = target;
                end
                if (imem_resp) begin
                    // A redirect arriving with the response is the newest target.
                    fetch_pc_d = redirect_valid ? target : redir_pc_q;
                    state_d    = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            redir_pc_q <= RESET_PC;
            buf_ir_q   <= NOP_INSN;
            buf_pc_q   <= 32'd0;
            ir_q       <= NOP_INSN;
            pc_q       <= 32'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            redir_pc_q <= redir_pc_d;
            buf_ir_q   <= buf_ir_d;
            buf_pc_q   <= buf_pc_d;
            ir_q       <= ir_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage: each row drives one cycle of inputs
// and lists the outputs expected just after the following rising edge.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] ir_out;
    logic [31:0] pc_out;
    logic        valid_out;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] JNK = 32'hDEADBEEF;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_address   (imem_address),
        .imem_read      (imem_read),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_out         (ir_out),
        .pc_out         (pc_out),
        .valid_out      (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        resp;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        rd;
        logic        v;
        logic [31:0] pc;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                       input logic resp, input logic [31:0] rdata, input logic [31:0] addr,
                       input logic rd, input logic v, input logic [31:0] pc,
                       input logic [31:0] ir);
        vec_t e;
        e.rst = r; e.stall = s; e.rv = rv; e.rpc = rpc; e.resp = resp; e.rdata = rdata;
        e.addr = addr; e.rd = rd; e.v = v; e.pc = pc; e.ir = ir;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                         input logic resp, input logic [31:0] rdata);
        @(negedge clk);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
        imem_resp = resp; imem_rdata = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int idx, input logic [31:0] addr, input logic rd,
                           input logic v, input logic [31:0] pc, input logic [31:0] ir);
        chk("imem_address", idx, imem_address, addr);
        chk("imem_read", idx, {31'd0, imem_read}, {31'd0, rd});
        chk("valid_out", idx, {31'd0, valid_out}, {31'd0, v});
        chk("pc_out", idx, pc_out, pc);
        chk("ir_out", idx, ir_out, ir);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_resp = 1'b0; imem_rdata = JNK;

        //   rst stall rv  rpc           resp rdata          addr          rd v  pc            ir
        add(1, 0, 0, 32'h0,         0, JNK,           32'h60,       1, 0, 32'h0,        NOP);
        // back-to-back responses
        add(0, 0, 0, 32'h0,         1, 32'hD0000060,  32'h64,       1, 1, 32'h60,       32'hD0000060);
        add(0, 0, 0, 32'h0,         1, 32'hD0000064,  32'h68,       1, 1, 32'h64,       32'hD0000064);
        add(0, 0, 0, 32'h0,         1, 32'hD0000068,  32'h6C,       1, 1, 32'h68,       32'hD0000068);
        // response under stall goes to the skid buffer, then drains
        add(0, 1, 0, 32'h0,         1, 32'hD000006C,  32'h70,       0, 1, 32'h68,       32'hD0000068);
        add(0, 1, 0, 32'h0,         0, JNK,           32'h70,       0, 1, 32'h68,       32'hD0000068);
        add(0, 1, 0, 32'h0,         0, JNK,           32'h70,       0, 1, 32'h68,       32'hD0000068);
        add(0, 0, 0, 32'h0,         0, JNK,           32'h70,       1, 1, 32'h6C,       32'hD000006C);
        add(0, 0, 0, 32'h0,         0, JNK,           32'h70,       1, 0, 32'h6C,       NOP);
        // redirect while read outstanding: old address held, rdata dropped
        add(0, 0, 1, 32'h200,       0, JNK,           32'h70,       1, 0, 32'h6C,       NOP);
        add(0, 0, 0, 32'h0,         0, JNK,           32'h70,       1, 0, 32'h6C,       NOP);
        add(0, 0, 0, 32'h0,         1, 32'hD0000070,  32'h200,      1, 0, 32'h6C,       NOP);
        add(0, 0, 0, 32'h0,         1, 32'hD0000200,  32'h204,      1, 1, 32'h200,      32'hD0000200);
        // redirect in DROP overwrites the parked target; unaligned target is masked
        add(0, 0, 1, 32'h301,       0, JNK,           32'h204,      1, 0, 32'h200,      NOP);
        add(0, 0, 1, 32'h400,       0, JNK,           32'h204,      1, 0, 32'h200,      NOP);
        add(0, 0, 0, 32'h0,         1, 32'hD0000204,  32'h400,      1, 0, 32'h200,      NOP);
        add(0, 0, 0, 32'h0,         1, 32'hD0000400,  32'h404,      1, 1, 32'h400,      32'hD0000400);
        // redirect + stall in HOLD discards the buffer
        add(0, 1, 0, 32'h0,         1, 32'hD0000404,  32'h408,      0, 1, 32'h400,      32'hD0000400);
        add(0, 1, 1, 32'h200,       0, JNK,           32'h200,      1, 0, 32'h400,      NOP);
        // redirect with a response in FETCH discards rdata immediately
        add(0, 0, 1, 32'h500,       1, 32'hD0000200,  32'h500,      1, 0, 32'h400,      NOP);
        // five-cycle response delay -> five bubbles
        add(0, 0, 0, 32'h0,         0, JNK,           32'h500,      1, 0, 32'h400,      NOP);
        add(0, 0, 0, 32'h0,         0, JNK,           32'h500,      1, 0, 32'h400,      NOP);
        add(0, 0, 0, 32'h0,         0, JNK,           32'h500,      1, 0, 32'h400,      NOP);
        add(0, 0, 0, 32'h0,         0, JNK,           32'h500,      1, 0, 32'h400,      NOP);
        add(0, 0, 0, 32'h0,         0, JNK,           32'h500,      1, 0, 32'h400,      NOP);
        add(0, 0, 0, 32'h0,         1, 32'hD0000500,  32'h504,      1, 1, 32'h500,      32'hD0000500);
        // PC wraps from 0xFFFFFFFC to 0
        add(0, 0, 1, 32'hFFFFFFFC,  1, 32'hD0000504,  32'hFFFFFFFC, 1, 0, 32'h500,      NOP);
        add(0, 0, 0, 32'h0,         1, 32'hDFFFFFFC,  32'h0,        1, 1, 32'hFFFFFFFC, 32'hDFFFFFFC);
        add(0, 1, 0, 32'h0,         1, 32'hD0000000,  32'h4,        0, 1, 32'hFFFFFFFC, 32'hDFFFFFFC);
        // reset in HOLD
        add(1, 1, 0, 32'h0,         0, JNK,           32'h60,       1, 0, 32'h0,        NOP);
        add(0, 0, 0, 32'h0,         0, JNK,           32'h60,       1, 0, 32'h0,        NOP);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].resp,
                  vecs[i].rdata);
            chk_all(i, vecs[i].addr, vecs[i].rd, vecs[i].v, vecs[i].pc, vecs[i].ir);
        end

        // DROP: new redirect arriving together with the old response wins
        drive(0, 0, 1, 32'h100, 0, JNK);
        chk_all(100, 32'h60, 1'b1, 1'b0, 32'h0, NOP);
        drive(0, 0, 1, 32'h180, 1, 32'hD0000060);
        chk_all(101, 32'h180, 1'b1, 1'b0, 32'h0, NOP);
        drive(0, 0, 0, 32'h0, 1, 32'hD0000180);
        chk_all(102, 32'h184, 1'b1, 1'b1, 32'h180, 32'hD0000180);
        // stall with no response in FETCH holds a valid IF/ID entry
        drive(0, 1, 0, 32'h0, 0, JNK);
        chk_all(103, 32'h184, 1'b1, 1'b1, 32'h180, 32'hD0000180);
        drive(0, 0, 0, 32'h0, 1, 32'hD0000184);
        chk_all(104, 32'h188, 1'b1, 1'b1, 32'h184, 32'hD0000184);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decode/control-word ROM.
- Owns the PC and drives the instruction-cache request.
- Presents a registered {ir, pc, valid} to decode.
- Handles downstream stall, branch/jump redirect from execute, and a cache that cannot abort an in-flight request.

Parameters:
RESET_PC, 32'h00000060, PC value loaded on reset
NOP_INSN, 32'h00000013, instruction presented on ir_out when valid_out=0 (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_address  out  32  instruction fetch address, word aligned
imem_read  out  1  fetch request; held until imem_resp
imem_rdata  in  32  instruction word, valid when imem_resp=1
imem_resp  in  1  one-cycle response pulse for the outstanding read
stall  in  1  decode/downstream cannot accept; IF/ID must hold
redirect_valid  in  1  taken branch/jal/jalr from execute; flush and refetch
redirect_pc  in  32  redirect target
ir_out  out  32  IF/ID instruction word to decode
pc_out  out  32  IF/ID PC of ir_out
valid_out  out  1  IF/ID holds a real instruction

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Registers:
  - fetch_pc: address of the current or next request.
  - buf_ir / buf_pc: one-entry skid buffer.
  - IF/ID: ir_out, pc_out, valid_out.
  - state: FETCH, HOLD or DROP.
- Reset values:
  - fetch_pc=RESET_PC, state=FETCH, valid_out=0, ir_out=NOP_INSN, pc_out=0.
  - imem_read is 1 in the first cycle after reset deassertion.
  - rst overrides everything mid-operation. A response arriving in or after the reset cycle for a pre-reset request is not possible; the cache is reset together with this block.
- imem_address = fetch_pc with bits [1:0] forced to 0.
  - imem_read=1 in FETCH and DROP, 0 in HOLD.
  - The address is stable while imem_read=1.
- imem_resp may arrive in any cycle imem_read=1, including the first cycle of the request.
- FETCH, no redirect:
  - resp & !stall: IF/ID <= {rdata, fetch_pc, 1}; fetch_pc += 4; stay FETCH. This is the back-to-back throughput of 1 instruction per response.
  - resp & stall: IF/ID holds; buf <= {rdata, fetch_pc}; fetch_pc += 4; go to HOLD.
  - !resp & !stall: valid_out <= 0 and ir_out <= NOP_INSN (bubble).
  - !resp & stall: IF/ID holds.
- HOLD, no redirect:
  - stall: everything holds.
  - !stall: IF/ID <= {buf_ir, buf_pc, 1}; go to FETCH. The next request begins the following cycle.
- Redirect (highest priority; wins over stall in the same cycle):
  - Always: valid_out <= 0, ir_out <= NOP_INSN; target = {redirect_pc[31:2], 2'b00}.
  - FETCH with resp this cycle: discard rdata; fetch_pc <= target; stay FETCH.
  - FETCH without resp: the request must complete. Save target in fetch_pc's shadow register redir_pc; go to DROP. imem_address stays on the old address.
  - HOLD: discard buffer; fetch_pc <= target; go to FETCH.
  - DROP: overwrite redir_pc with the new target.
- DROP:
  - imem_read=1 on the old address.
  - On resp: discard rdata; fetch_pc <= redir_pc; go to FETCH.
  - IF/ID stays valid_out=0.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 wraps to 0.
- Invariant: no instruction is ever lost or duplicated; pc_out sequence equals program order, modulo redirects.

Test Plan:
- Reset, resp every cycle, stall=0 -> imem_address 0x60, 0x64, 0x68…; pc_out/valid_out follow one cycle after each resp; ir_out matches rdata.
- Resp at 0x64 while stall=1 for 3 cycles -> imem_read drops to 0 and IF/ID holds 0x60 throughout. One cycle after stall falls: pc_out=0x64, ir_out = the 0x64 word. The next request is at 0x68.
- redirect_valid with redirect_pc=0x200, no resp pending that cycle (read outstanding at 0x70) -> imem_address remains 0x70 until resp. That rdata is dropped and valid_out stays 0. The next request is at 0x200.
- Redirect 0x300 in DROP, then redirect 0x400 before resp -> only 0x400 is fetched.
- Redirect and stall in the same cycle while in HOLD -> buffer discarded, valid_out=0, next address 0x200.
- Resp delayed 5 cycles with stall=0 -> 5 bubbles (valid_out=0, ir_out=0x00000013).
- rst asserted mid-HOLD -> next cycle valid_out=0, address 0x60.
